// File: rtl/ft_tx_sched.sv
// ft_tx_sched
//   Shares the single FT245 synchronous-FIFO write port between two byte
//   streams: source 0 (FFT output) and source 1 (raw/FIR samples). Each grant
//   sends one framed packet: SYNC_BYTE, an ID byte {source, 7-bit sequence},
//   then FRAME_LEN payload bytes from the granted source. An idle gap follows
//   every packet so host bandwidth stays under the FT2232H limit.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   en                  allows new grants (a packet in flight always finishes)
//   s0_data/valid/ready source 0 valid/ready byte stream
//   s1_data/valid/ready source 1 valid/ready byte stream
//   ft_txe_n            FT245 can accept a byte when low
//   ft_wr_n, ft_data    FT245 write strobe (active low) and byte
//   grant               source owning the port (meaningful while busy)
//   busy                high whenever a packet or its gap is in progress
module ft_tx_sched #(
  parameter int unsigned FRAME_LEN  = 1024,
  parameter int unsigned GAP_CYCLES = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  output logic       s1_ready,
  input  logic       ft_txe_n,
  output logic       ft_wr_n,
  output logic [7:0] ft_data,
  output logic       grant,
  output logic       busy
);

  // Counter value of the final payload byte and of the final gap cycle.
  // A zero-length gap still spends one cycle in the gap state.
  localparam logic [15:0] LastByte = 16'(FRAME_LEN - 1);
  localparam logic [15:0] LastGap  = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StId,
    StPayload,
    StGap
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        lastGrant_q, lastGrant_d;
  logic [6:0]  seq0_q, seq0_d;
  logic [6:0]  seq1_q, seq1_d;
  logic [15:0] byteCnt_q, byteCnt_d;
  logic [15:0] gapCnt_q, gapCnt_d;

  logic [7:0]  srcData;
  logic        srcValid;
  logic [6:0]  curSeq;
  logic        pick;

  // Views of whichever source currently owns the port.
  assign srcData  = grant_q ? s1_data  : s0_data;
  assign srcValid = grant_q ? s1_valid : s0_valid;
  assign curSeq   = grant_q ? seq1_q   : seq0_q;

  assign grant = grant_q;
  assign busy  = (state_q != StIdle);

  // State and bookkeeping registers. The last-grant register starts at 1 so
  // that source 0 wins the very first tie after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      seq0_q      <= 7'd0;
      seq1_q      <= 7'd0;
      byteCnt_q   <= 16'd0;
      gapCnt_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      seq0_q      <= seq0_d;
      seq1_q      <= seq1_d;
      byteCnt_q   <= byteCnt_d;
      gapCnt_q    <= gapCnt_d;
    end
  end

  // Next-state and output logic. The FT245 handshake passes straight through
  // to the granted source's ready, so a payload byte moves on exactly the
  // edges where the source is valid and the FT245 has room.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    seq0_d      = seq0_q;
    seq1_d      = seq1_q;
    byteCnt_d   = byteCnt_q;
    gapCnt_d    = gapCnt_q;
    pick        = 1'b0;
    ft_wr_n     = 1'b1;
    ft_data     = 8'h00;
    s0_ready    = 1'b0;
    s1_ready    = 1'b0;

    case (state_q)
      StIdle: begin
        if (en && (s0_valid || s1_valid)) begin
          // On a tie, hand the port to whichever source did not have it last.
          pick        = (s0_valid && s1_valid) ? ~lastGrant_q : s1_valid;
          grant_d     = pick;
          lastGrant_d = pick;
          state_d     = StSync;
        end
      end

      StSync: begin
        ft_wr_n = 1'b0;
        ft_data = SYNC_BYTE;
        if (!ft_txe_n) begin
          state_d = StId;
        end
      end

      StId: begin
        ft_wr_n = 1'b0;
        ft_data = {grant_q, curSeq};
        if (!ft_txe_n) begin
          state_d   = StPayload;
          byteCnt_d = 16'd0;
        end
      end

      StPayload: begin
        ft_data  = srcData;
        ft_wr_n  = ~srcValid;
        s0_ready = ~grant_q & ~ft_txe_n;
        s1_ready = grant_q & ~ft_txe_n;
        if (srcValid && !ft_txe_n) begin
          byteCnt_d = byteCnt_q + 16'd1;
          if (byteCnt_q == LastByte) begin
            if (grant_q) begin
              seq1_d = seq1_q + 7'd1;
            end else begin
              seq0_d = seq0_q + 7'd1;
            end
            state_d  = StGap;
            gapCnt_d = 16'd0;
          end
        end
      end

      StGap: begin
        if (gapCnt_q == LastGap) begin
          state_d = StIdle;
        end else begin
          gapCnt_d = gapCnt_q + 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_ft_tx_sched.sv
// tb_ft_tx_sched
//   Bench for ft_tx_sched with FRAME_LEN=4, GAP_CYCLES=3. A reference model
//   tracks each packet as a position along its timeline (idle, sync, id,
//   payload bytes, gap cycles) and predicts every output each cycle; directed
//   scenarios pin the model with hand-computed byte streams, and a random
//   phase exercises stalls, contention, enable and reset.
module tb_ft_tx_sched;

  localparam int         FRAME_LEN  = 4;
  localparam int         GAP_CYCLES = 3;
  localparam logic [7:0] SYNC       = 8'hA5;
  localparam int         PAYEND     = FRAME_LEN + 2;
  localparam int         GAPN       = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
  localparam int         LASTPOS    = PAYEND + GAPN;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] s0_data = 8'h00;
  logic       s0_valid = 1'b0;
  logic       s0_ready;
  logic [7:0] s1_data = 8'h00;
  logic       s1_valid = 1'b0;
  logic       s1_ready;
  logic       ft_txe_n = 1'b1;
  logic       ft_wr_n;
  logic [7:0] ft_data;
  logic       grant;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit checkEn = 1'b0;

  logic [7:0] capQ[$];
  int         capCyc[$];

  ft_tx_sched #(
    .FRAME_LEN (FRAME_LEN),
    .GAP_CYCLES(GAP_CYCLES),
    .SYNC_BYTE (SYNC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .s0_data (s0_data),
    .s0_valid(s0_valid),
    .s0_ready(s0_ready),
    .s1_data (s1_data),
    .s1_valid(s1_valid),
    .s1_ready(s1_ready),
    .ft_txe_n(ft_txe_n),
    .ft_wr_n (ft_wr_n),
    .ft_data (ft_data),
    .grant   (grant),
    .busy    (busy)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus: drive inputs, note handshakes mid-cycle,
  // then step each source to its next byte after a consumed byte.
  task automatic applyStimulus(input logic v0, input logic v1, input logic txeN, input logic enI);
    logic hs0, hs1;
    s0_valid = v0;
    s1_valid = v1;
    ft_txe_n = txeN;
    en       = enI;
    @(negedge clk);
    hs0 = s0_valid & s0_ready;
    hs1 = s1_valid & s1_ready;
    @(posedge clk);
    #1;
    if (hs0) s0_data = s0_data + 8'd1;
    if (hs1) s1_data = s1_data + 8'd1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    s0_data = 8'h10;
    s1_data = 8'h40;
    capQ.delete();
    capCyc.delete();
  endtask

  // Record every byte the FT245 accepts.
  always @(negedge clk) begin
    if (!rst && !ft_wr_n && !ft_txe_n) begin
      capQ.push_back(ft_data);
      capCyc.push_back(cyc);
    end
  end

  // Reference model: position 0 is idle, 1 sync, 2 id, 3..PAYEND payload,
  // then GAPN gap positions ending at LASTPOS.
  int         mPos = 0;
  bit         mSrc = 1'b0;
  bit         mLast = 1'b1;
  bit   [6:0] mSeq[2];

  always @(posedge clk) begin
    if (rst) begin
      mPos = 0;
      mSrc = 1'b0;
      mLast = 1'b1;
      mSeq[0] = 7'd0;
      mSeq[1] = 7'd0;
    end else if (mPos == 0) begin
      if (en && (s0_valid || s1_valid)) begin
        mSrc  = (s0_valid && s1_valid) ? !mLast : s1_valid;
        mLast = mSrc;
        mPos  = 1;
      end
    end else if (mPos <= 2) begin
      if (!ft_txe_n) mPos++;
    end else if (mPos <= PAYEND) begin
      if ((mSrc ? s1_valid : s0_valid) && !ft_txe_n) begin
        if (mPos == PAYEND) mSeq[mSrc] = mSeq[mSrc] + 7'd1;
        mPos++;
      end
    end else begin
      mPos = (mPos == LASTPOS) ? 0 : mPos + 1;
    end
  end

  // Compare every DUT output against the model each cycle.
  always @(negedge clk) begin
    logic       expWr, expR0, expR1, srcV;
    logic [7:0] expData;
    if (checkEn) begin
      srcV    = mSrc ? s1_valid : s0_valid;
      expWr   = 1'b1;
      expData = 8'h00;
      expR0   = 1'b0;
      expR1   = 1'b0;
      if (mPos == 1) begin
        expWr   = 1'b0;
        expData = SYNC;
      end else if (mPos == 2) begin
        expWr   = 1'b0;
        expData = {mSrc, mSeq[mSrc]};
      end else if (mPos >= 3 && mPos <= PAYEND) begin
        expWr   = !srcV;
        expData = mSrc ? s1_data : s0_data;
        expR0   = !mSrc && !ft_txe_n;
        expR1   = mSrc && !ft_txe_n;
      end
      checkOutput("busy", 16'(busy), 16'(mPos != 0));
      if (mPos != 0) checkOutput("grant", 16'(grant), 16'(mSrc));
      checkOutput("ft_wr_n", 16'(ft_wr_n), 16'(expWr));
      checkOutput("ft_data", 16'(ft_data), 16'(expData));
      checkOutput("s0_ready", 16'(s0_ready), 16'(expR0));
      checkOutput("s1_ready", 16'(s1_ready), 16'(expR1));
    end
  end

  initial begin
    logic [7:0] expPay;

    // Reset state.
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkEn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_wr_n", 16'(ft_wr_n), 16'd1);
    checkOutput("rst_data", 16'(ft_data), 16'd0);
    checkOutput("rst_grant", 16'(grant), 16'd0);
    checkOutput("rst_s0_ready", 16'(s0_ready), 16'd0);
    checkOutput("rst_s1_ready", 16'(s1_ready), 16'd0);

    // Single source streaming: one packet, gap, next packet's ID.
    doReset();
    repeat (13) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("p1_count", 16'(capQ.size()), 16'd8);
    if (capQ.size() >= 8) begin
      checkOutput("p1_sync", 16'(capQ[0]), 16'hA5);
      checkOutput("p1_id", 16'(capQ[1]), 16'h00);
      for (int j = 0; j < 4; j++) checkOutput("p1_payload", 16'(capQ[2+j]), 16'(8'h10 + 8'(j)));
      checkOutput("p2_sync", 16'(capQ[6]), 16'hA5);
      checkOutput("p2_id", 16'(capQ[7]), 16'h01);
      checkOutput("gap_cycles", 16'(capCyc[6] - capCyc[5]), 16'd5);
    end

    // Both sources continuously valid: round-robin alternation.
    doReset();
    repeat (40) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("rr_count", 16'(capQ.size()), 16'd24);
    if (capQ.size() >= 24) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput("rr_sync", 16'(capQ[6*k]), 16'hA5);
        checkOutput("rr_id", 16'(capQ[6*k+1]), 16'({k[0], 7'(k / 2)}));
        for (int j = 0; j < 4; j++) begin
          expPay = (k[0] ? 8'h40 : 8'h10) + 8'(4 * (k / 2) + j);
          checkOutput("rr_payload", 16'(capQ[6*k+2+j]), 16'(expPay));
        end
      end
    end

    // FT245 full for 5 cycles while payload byte 2 is presented.
    doReset();
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (5) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("txe_hold_data", 16'(ft_data), 16'h12);
      checkOutput("txe_hold_ready", 16'(s0_ready), 16'd0);
    end
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("txe_count", 16'(capQ.size()), 16'd6);
    if (capQ.size() >= 6)
      for (int j = 0; j < 4; j++) checkOutput("txe_payload", 16'(capQ[2+j]), 16'(8'h10 + 8'(j)));

    // Source 1 drops valid mid-packet while source 0 waits.
    doReset();
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("s1stall_wr_n", 16'(ft_wr_n), 16'd1);
      checkOutput("s1stall_s0_ready", 16'(s0_ready), 16'd0);
    end
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("s1stall_count", 16'(capQ.size()), 16'd6);
    if (capQ.size() >= 6) begin
      checkOutput("s1stall_id", 16'(capQ[1]), 16'h80);
      for (int j = 0; j < 4; j++) checkOutput("s1stall_payload", 16'(capQ[2+j]), 16'(8'h40 + 8'(j)));
    end

    // 128 source-0 packets: sequence wraps; then en drops mid-packet.
    doReset();
    repeat (128 * 10 + 3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("wrap_count", 16'(capQ.size()), 16'(128 * 6 + 2));
    if (capQ.size() >= 128 * 6 + 2)
      for (int k = 0; k <= 128; k++) checkOutput("wrap_id", 16'(capQ[6*k+1]), 16'(k % 128));
    repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("en_off_busy", 16'(busy), 16'd0);
    checkOutput("en_off_count", 16'(capQ.size()), 16'(129 * 6));

    // Reset pulsed during payload.
    doReset();
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("midrst_wr_n", 16'(ft_wr_n), 16'd1);
    checkOutput("midrst_busy", 16'(busy), 16'd0);
    checkOutput("midrst_grant", 16'(grant), 16'd0);
    rst = 1'b0;
    s0_data = 8'h10;
    capQ.delete();
    capCyc.delete();
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("midrst_count", 16'(capQ.size()), 16'd2);
    if (capQ.size() >= 2) begin
      checkOutput("midrst_sync", 16'(capQ[0]), 16'hA5);
      checkOutput("midrst_id", 16'(capQ[1]), 16'h00);
    end

    // Random traffic checked cycle by cycle against the model.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 9) != 0);
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
